// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl_if
// Description : Signal bundle between the divide sequencing controller and
//               the shared radix-2 divider core.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_hold;
    logic             div_busy;
    logic             div_finish;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // Controller side: launches the core and collects its result
    modport master (
        output div_start,
        output div_dividend,
        output div_divisor,
        output div_hold,
        input  div_busy,
        input  div_finish,
        input  div_q,
        input  div_r
    );

    // Core side
    modport slave (
        input  div_start,
        input  div_dividend,
        input  div_divisor,
        input  div_hold,
        output div_busy,
        output div_finish,
        output div_q,
        output div_r
    );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_seq_ctrl
// Description : Sequences DIV/DIVU between the EX stage and an unsigned
//               32-cycle divider core: takes operand magnitudes, waits for
//               the core, applies sign fix-up and writes HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq_ctrl #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             req,
    input  wire logic             is_signed,
    input  wire logic [WIDTH-1:0] op_a,
    input  wire logic [WIDTH-1:0] op_b,
    input  wire logic             flush,
    input  wire logic             ext_hold,
    div_seq_ctrl_if.master        dif,
    output logic      [WIDTH-1:0] hi,
    output logic      [WIDTH-1:0] lo,
    output logic                  hilo_we,
    output logic                  stall_req
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Busy is informational only; the FSM tracks the core by its finish pulse
    logic             w_unused_busy;
    assign w_unused_busy = dif.div_busy;

    // Two's complement negate; -0x80000000 wraps to itself, which the signed
    // overflow case relies on
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
        return ~x + c_ONE;
    endfunction

    assign w_accept = (r_state == S_IDLE) & req & ~flush;
    assign w_mag_a  = (is_signed & op_a[WIDTH-1]) ? f_neg(op_a) : op_a;
    assign w_mag_b  = (is_signed & op_b[WIDTH-1]) ? f_neg(op_b) : op_b;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control outputs; flush aborts any in-flight stage
    always_comb begin
        w_next    = r_state;
        hilo_we   = 1'b0;
        stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                // reset gating keeps the stall request low while held in reset
                stall_req = w_accept & reset;
                if (w_accept) begin
                    w_next = (op_b == '0) ? S_FIXUP : S_START;
                end
            end
            S_START: begin
                stall_req = 1'b1;
                w_next    = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (flush) begin
                    w_next = S_IDLE;
                end else if (dif.div_finish) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                stall_req = 1'b1;
                w_next    = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                hilo_we = ~flush;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, core result capture and HI/LO fix-up
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= op_a;
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_neg_q <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                r_neg_r <= is_signed & op_a[WIDTH-1];
                r_div0  <= (op_b == '0);
            end
            if ((r_state == S_WAIT) && dif.div_finish && !flush) begin
                r_q <= dif.div_q;
                r_r <= dif.div_r;
            end
            if ((r_state == S_FIXUP) && !flush) begin
                if (r_div0) begin
                    r_lo <= DIV0_LO;
                    r_hi <= r_a;
                end else begin
                    r_lo <= r_neg_q ? f_neg(r_q) : r_q;
                    r_hi <= r_neg_r ? f_neg(r_r) : r_r;
                end
            end
        end
    end

    assign dif.div_start    = (r_state == S_START);
    assign dif.div_dividend = r_mag_a;
    assign dif.div_divisor  = r_mag_b;
    assign dif.div_hold     = (r_state == S_WAIT) & ext_hold;
    assign hi               = r_hi;
    assign lo               = r_lo;

endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller between the EX stage and the shared 32-cycle unsigned radix-2 divider core.
- Accepts DIV/DIVU issue requests and converts signed operands to magnitudes before starting the core.
- Waits for the core's finish pulse, applies sign fix-up, and delivers HI/LO with a one-cycle write strobe.
- Raises the pipeline stall request for the duration and handles divide-by-zero, flush and pipeline hold.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  1  EX stage holds a DIV/DIVU; held high while stall_req=1.
- is_signed  input  1  1=DIV, 0=DIVU; sampled with req.
- op_a  input  32  dividend; sampled on acceptance.
- op_b  input  32  divisor; sampled on acceptance.
- flush  input  1  pipeline flush; cancels the current operation.
- ext_hold  input  1  downstream pipeline stall; freezes the core.
- div_start  output  1  start pulse to the core.
- div_dividend  output  32  magnitude of dividend to the core.
- div_divisor  output  32  magnitude of divisor to the core.
- div_hold  output  1  driven to the core's cpu_stall input.
- div_busy  input  1  core busy (monitor only).
- div_finish  input  1  core one-cycle completion pulse.
- div_q  input  32  core quotient.
- div_r  input  32  core remainder.
- hi  output  32  remainder result, registered.
- lo  output  32  quotient result, registered.
- hilo_we  output  1  HI/LO write strobe.
- stall_req  output  1  stall request to the hazard unit.

Behaviour:
- Reset (reset=0, any state, including mid-division): state=IDLE; hi=0, lo=0; all operand registers=0; hilo_we=0, div_start=0, stall_req=0.
- States: IDLE, START, WAIT, FIXUP, DONE (one-hot or binary encoding).
- IDLE, acceptance: when req=1 and flush=0, register op_a, op_b, is_signed, neg_q=is_signed&(a[31]^b[31]), neg_r=is_signed&a[31].
  - Magnitudes: |x| = is_signed&x[31] ? ~x+1 : x.
  - If op_b==0, go to FIXUP with div0 flag set; otherwise go to START.
- START: div_start=1 for exactly one cycle, with div_dividend/div_divisor = registered magnitudes; next state is WAIT.
- WAIT: div_hold=ext_hold; outside WAIT, div_hold=0.
  - div_finish is ignored in all states except WAIT; stale pulses from aborted operations are harmless because START re-initialises the core.
  - On div_finish=1, capture div_q/div_r and go to FIXUP.
- FIXUP (one cycle): lo <= neg_q ? -q : q; hi <= neg_r ? -r : r.
  - If div0: lo <= DIV0_LO, hi <= op_a (raw).
  - 0x80000000 / -1 signed yields lo=0x80000000, hi=0 naturally; no special case.
  - Next state is DONE.
- DONE (one cycle): hilo_we = !flush; next state is IDLE.
  - req is ignored in DONE; the pipeline advances at this edge.
- stall_req = (state in START, WAIT, FIXUP) | (state==IDLE & req & !flush); 0 in DONE.
- Latency, no hold: req accepted in cycle 0; START in cycle 1; WAIT in cycles 2..34 (finish seen in cycle 34); FIXUP in cycle 35; DONE with hilo_we in cycle 36.
  - Each ext_hold cycle in WAIT adds one cycle.
  - Divide-by-zero: DONE in cycle 2.
- flush=1 in START, WAIT or FIXUP: go to IDLE at the next edge; hi/lo unchanged; no hilo_we. The core is left running and is overridden by the next start.
- flush and req both high in IDLE: not accepted.
- hi/lo hold their values between operations.

Test Plan:
- DIVU 100/7, no hold -> stall_req high in cycles 0..35, hilo_we only in cycle 36, lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIV 20/-6 -> lo=0xFFFFFFFD, hi=2.
- Divide-by-zero, op_a=5, op_b=0 -> div_start never asserted, hilo_we in cycle 2, lo=0xFFFFFFFF, hi=5.
- DIVU 1000/3 with flush in cycle 10 -> IDLE at cycle 11, no hilo_we, hi/lo unchanged; then DIVU 9/3 -> lo=3, hi=0 at its cycle 36, with the stale core activity ignored.
- ext_hold high for 5 cycles during WAIT on 100/7 -> div_hold mirrors ext_hold; DONE in cycle 41.
- reset=0 asserted in cycle 20 -> immediate IDLE, all outputs 0; a fresh request completes normally.
